// File: rtl/data_memory_unit.sv
// Handshaked big-endian data memory with byte/half/word access, load extension,
// configurable wait states and an error flag for misaligned or out-of-range accesses.
module data_memory_unit #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  r_wbar,
    input  logic [1:0]            Mode,
    input  logic                  Unsigned,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           WriteData,
    output logic [31:0]           ReadData,
    output logic                  ready,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            mode_q;
    logic                  uns_q;
    logic                  rd_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  ready_q;
    logic                  busy_q;
    logic                  err_q;

    logic [31:0]           mem [DEPTH_WORDS];

    logic [IDX_W-1:0]      idx_c;
    logic [1:0]            lane_c;
    logic [31:0]           word_c;
    logic [7:0]            byte_c;
    logic [15:0]           half_c;
    logic                  done_c;
    logic                  we_c;
    logic                  err_d;
    logic [31:0]           rdata_d;
    logic [31:0]           wword_d;

    assign idx_c  = addr_q[IDX_W+1:2];
    assign lane_c = addr_q[1:0];
    assign word_c = mem[idx_c];
    assign done_c = (state_q == S_WAIT) && (cnt_q == '0);
    assign we_c   = done_c && !rd_q && !err_d && !reset;

    // Alignment, reserved-mode and range checks on the captured request
    always_comb begin
        err_d = 1'b0;
        case (mode_q)
            2'b00:   err_d = 1'b0;
            2'b01:   err_d = addr_q[0];
            2'b10:   err_d = |addr_q[1:0];
            default: err_d = 1'b1;
        endcase
        if ((addr_q >> (IDX_W + 2)) != '0) err_d = 1'b1;
    end

    // Load path: lane 0 is the most significant byte
    always_comb begin
        rdata_d = '0;
        byte_c  = '0;
        case (lane_c)
            2'd0:    byte_c = word_c[31:24];
            2'd1:    byte_c = word_c[23:16];
            2'd2:    byte_c = word_c[15:8];
            default: byte_c = word_c[7:0];
        endcase
        half_c = lane_c[1] ? word_c[15:0] : word_c[31:16];
        case (mode_q)
            2'b00:   rdata_d = uns_q ? {24'b0, byte_c} : {{24{byte_c[7]}}, byte_c};
            2'b01:   rdata_d = uns_q ? {16'b0, half_c} : {{16{half_c[15]}}, half_c};
            2'b10:   rdata_d = word_c;
            default: rdata_d = '0;
        endcase
        if (err_d) rdata_d = '0;
    end

    // Store path: merge new lane(s) into the existing word
    always_comb begin
        wword_d = word_c;
        case (mode_q)
            2'b00: begin
                case (lane_c)
                    2'd0:    wword_d[31:24] = wdata_q[7:0];
                    2'd1:    wword_d[23:16] = wdata_q[7:0];
                    2'd2:    wword_d[15:8]  = wdata_q[7:0];
                    default: wword_d[7:0]   = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (lane_c[1]) wword_d[15:0]  = wdata_q[15:0];
                else           wword_d[31:16] = wdata_q[15:0];
            end
            2'b10:   wword_d = wdata_q;
            default: wword_d = word_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we_c) mem[idx_c] <= wword_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            mode_q  <= '0;
            uns_q   <= 1'b0;
            rd_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        addr_q  <= Address;
                        mode_q  <= Mode;
                        uns_q   <= Unsigned;
                        rd_q    <= r_wbar;
                        wdata_q <= WriteData;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                default: begin
                    if (cnt_q == '0) begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        err_q   <= err_d;
                        // Errors force a zero result even on a store completion
                        if (rd_q || err_d) rdata_q <= rdata_d;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign ReadData = rdata_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: directed vector table, handshake/reset sequences,
// and random accesses checked against a byte-array reference model.
module tb_data_memory_unit;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned LAT   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        r_wbar = 1'b1;
    logic [1:0]  Mode = 2'b10;
    logic        Unsigned = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        ready;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    // Reference model: flat big-endian byte store plus held result registers
    logic [7:0]  mb [4*DEPTH];
    logic [31:0] m_rdata = '0;
    logic        m_err = 1'b0;

    data_memory_unit #(
        .DEPTH_WORDS(DEPTH),
        .ADDR_WIDTH (32),
        .LATENCY    (LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .r_wbar   (r_wbar),
        .Mode     (Mode),
        .Unsigned (Unsigned),
        .Address  (Address),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .ready    (ready),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [1:0]  md;
        logic        us;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic model(input logic rd, input logic [1:0] md, input logic us,
                         input logic [31:0] a, input logic [31:0] wd);
        int nb;
        logic [31:0] v;
        nb = (md == 2'b00) ? 1 : (md == 2'b01) ? 2 : 4;
        m_err = (md == 2'b11) || ((a % 32'(nb)) != 0) || (a >= 32'(4*DEPTH));
        if (m_err) begin
            m_rdata = '0;
        end else if (rd) begin
            v = '0;
            for (int i = 0; i < nb; i++) v = (v << 8) | 32'(mb[int'(a) + i]);
            if (nb < 4 && !us && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            m_rdata = v;
        end else begin
            for (int i = 0; i < nb; i++) mb[int'(a) + i] = 8'(wd >> (8*(nb-1-i)));
        end
    endtask

    // One complete access with latency, busy and pulse-width checks
    task automatic access(input logic rd, input logic [1:0] md, input logic us,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rdo, output logic eo);
        @(negedge clk);
        req = 1'b1; r_wbar = rd; Mode = md; Unsigned = us; Address = a; WriteData = wd;
        @(posedge clk); #1;
        req = 1'b0;
        Address = $urandom; WriteData = $urandom; Mode = 2'($urandom); Unsigned = 1'($urandom);
        r_wbar = 1'($urandom);
        chk("busy_at_accept", {31'b0, busy}, 32'd1);
        for (int i = 1; i < int'(LAT); i++) begin
            @(posedge clk); #1;
            chk("ready_early", {31'b0, ready}, 32'd0);
            chk("busy_wait", {31'b0, busy}, 32'd1);
        end
        @(posedge clk); #1;
        chk("ready_pulse", {31'b0, ready}, 32'd1);
        chk("busy_fall", {31'b0, busy}, 32'd0);
        rdo = ReadData;
        eo  = err;
        @(posedge clk); #1;
        chk("ready_one_cycle", {31'b0, ready}, 32'd0);
        chk("rdata_hold", ReadData, rdo);
    endtask

    vec_t vecs[16];

    initial begin
        logic [31:0] rdo;
        logic        eo;
        logic        seen;
        logic        rd;
        logic [1:0]  md;
        logic        us;
        logic [31:0] a;
        logic [31:0] wd;

        vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h44,  32'h71FD6806, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 2'b10, 1'b0, 32'h44,  32'h0,        32'h71FD6806, 1'b0};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h45,  32'h000000AB, 32'h71FD6806, 1'b0};
        vecs[3]  = '{1'b1, 2'b10, 1'b0, 32'h44,  32'h0,        32'h71AB6806, 1'b0};
        vecs[4]  = '{1'b1, 2'b00, 1'b0, 32'h45,  32'h0,        32'hFFFFFFAB, 1'b0};
        vecs[5]  = '{1'b1, 2'b00, 1'b1, 32'h45,  32'h0,        32'h000000AB, 1'b0};
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 32'h46,  32'h0,        32'h00006806, 1'b0};
        vecs[7]  = '{1'b1, 2'b01, 1'b0, 32'h44,  32'h0,        32'h000071AB, 1'b0};
        vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h46,  32'h0,        32'h00000000, 1'b1};
        vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h45,  32'h1234,     32'h00000000, 1'b1};
        vecs[10] = '{1'b1, 2'b10, 1'b0, 32'h44,  32'h0,        32'h71AB6806, 1'b0};
        vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h100, 32'h0,        32'h00000000, 1'b1};
        vecs[12] = '{1'b0, 2'b00, 1'b0, 32'h47,  32'hFFFFFF80, 32'h00000000, 1'b0};
        vecs[13] = '{1'b1, 2'b00, 1'b0, 32'h47,  32'h0,        32'hFFFFFF80, 1'b0};
        vecs[14] = '{1'b1, 2'b01, 1'b1, 32'h46,  32'h0,        32'h00006880, 1'b0};
        vecs[15] = '{1'b1, 2'b11, 1'b0, 32'h44,  32'h0,        32'h00000000, 1'b1};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", ReadData, 32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        @(negedge clk) reset = 1'b0;

        // Directed table
        for (int i = 0; i < 16; i++) begin
            access(vecs[i].rd, vecs[i].md, vecs[i].us, vecs[i].a, vecs[i].wd, rdo, eo);
            model(vecs[i].rd, vecs[i].md, vecs[i].us, vecs[i].a, vecs[i].wd);
            chk($sformatf("vec%0d_rdata", i), rdo, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'b0, eo}, {31'b0, vecs[i].exp_err});
        end

        // req held high: one acceptance per LAT+1 cycles
        @(negedge clk);
        req = 1'b1; r_wbar = 1'b1; Mode = 2'b10; Unsigned = 1'b0; Address = 32'h44;
        for (int i = 1; i <= 4*int'(LAT+1); i++) begin
            @(posedge clk); #1;
            chk($sformatf("held_ready_e%0d", i), {31'b0, ready},
                {31'b0, (i % int'(LAT+1)) == 0});
            chk($sformatf("held_busy_e%0d", i), {31'b0, busy},
                {31'b0, (i % int'(LAT+1)) != 0});
        end
        req = 1'b0;
        model(1'b1, 2'b10, 1'b0, 32'h44, 32'h0);
        chk("held_rdata", ReadData, m_rdata);

        // Reset during a write aborts it
        @(negedge clk);
        req = 1'b1; r_wbar = 1'b0; Mode = 2'b10; Address = 32'h44; WriteData = 32'hDEADBEEF;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_ready", {31'b0, ready}, 32'd0);
        chk("abort_rdata", ReadData, 32'd0);
        chk("abort_err", {31'b0, err}, 32'd0);
        seen = 1'b0;
        repeat (LAT + 1) begin
            @(posedge clk); #1;
            if (ready) seen = 1'b1;
        end
        chk("abort_no_ready", {31'b0, seen}, 32'd0);
        @(negedge clk) reset = 1'b0;
        m_rdata = '0;
        m_err   = 1'b0;
        access(1'b1, 2'b10, 1'b0, 32'h44, 32'h0, rdo, eo);
        model(1'b1, 2'b10, 1'b0, 32'h44, 32'h0);
        chk("abort_reread", rdo, m_rdata);
        chk("abort_reread_err", {31'b0, eo}, {31'b0, m_err});

        // Fill memory so every random read is defined
        for (int w = 0; w < int'(DEPTH); w++) begin
            wd = $urandom;
            access(1'b0, 2'b10, 1'b0, 32'(4*w), wd, rdo, eo);
            model(1'b0, 2'b10, 1'b0, 32'(4*w), wd);
        end

        // Random accesses against the model
        for (int n = 0; n < 300; n++) begin
            rd = 1'($urandom);
            md = 2'($urandom);
            us = 1'($urandom);
            a  = $urandom_range(0, 4*DEPTH + 15);
            wd = $urandom;
            access(rd, md, us, a, wd, rdo, eo);
            model(rd, md, us, a, wd);
            chk($sformatf("rnd%0d_rdata", n), rdo, m_rdata);
            chk($sformatf("rnd%0d_err", n), {31'b0, eo}, {31'b0, m_err});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory_unit.md
# data_memory_unit

Parametrised, handshaked successor to the single-cycle data memory in the MIPS datapath. It provides byte-addressed, big-endian storage with byte, halfword and word access modes, sign or zero extension on loads, and a configurable number of wait states. Misaligned and out-of-range accesses are reported through an error flag. It sits between the MEM stage and backing storage; the pipeline stalls while `busy` is high.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, ≥ 4.
- ADDR_WIDTH, 32: width of the byte address.
- LATENCY, 2: cycles from acceptance to completion; must be ≥ 1.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- r_wbar  in  1  1 = read, 0 = write.
- Mode  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- Unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- Address  in  ADDR_WIDTH  byte address.
- WriteData  in  32  store data, right-justified (the byte uses [7:0], the half uses [15:0]).
- ReadData  out  32  load result; registered.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high while an access is in flight.
- err  out  1  completion status; valid with `ready`.

## Operation
- FSM states:
  - IDLE: `busy` = 0. When `req` = 1, capture `Address`, `Mode`, `Unsigned`, `r_wbar` and `WriteData`, load the counter with LATENCY−1, and go to WAIT.
  - WAIT: `busy` = 1. Decrement the counter each cycle. When the counter is 0, perform the access, pulse `ready`, and return to IDLE.
- Word index is `Address[log2(DEPTH_WORDS)+1:2]`. Byte lane `b` = `Address[1:0]`. Lane 0 is bits [31:24] (big-endian).
- Error conditions:
  - Mode = 11.
  - Halfword with `Address[0]` = 1.
  - Word with `Address[1:0]` ≠ 0.
  - Any `Address` bit above `log2(DEPTH_WORDS)+1` is set (out of range).
- On error: memory is unchanged, `ReadData` = 0, `err` = 1.
- Loads:
  - Select the addressed byte or half, right-justify it, then extend it per `Unsigned`.
  - A word load returns the full word; `Unsigned` is ignored.
- Stores: update only the addressed lane(s); all other bytes are preserved.
- `req` while `busy` is ignored and not queued. Inputs may change freely after the acceptance edge.
- `ReadData` updates only on a read completion and holds until the next read completion. Write completions leave it unchanged.
- `err` updates on every completion and holds until the next completion.
- The memory array is not reset; its contents are undefined until written.

## Timing
- Reset values: `ReadData` = 0, `ready` = 0, `busy` = 0, `err` = 0, FSM = IDLE, counter = 0.
- Acceptance happens at edge k. `busy` is high from edge k to edge k+LATENCY.
- At edge k+LATENCY:
  - the write is committed;
  - `ReadData` and `err` are updated;
  - `ready` goes high for exactly one cycle;
  - `busy` falls.
- The next request can be accepted at edge k+LATENCY+1. Maximum throughput is one access per LATENCY+1 cycles.
- Reset asserted mid-access:
  - the access is aborted immediately (asynchronously);
  - no write is committed;
  - `ready` never pulses for that access;
  - outputs return to their reset values.
- LATENCY = 1 is the minimum case: acceptance at edge k, completion at edge k+1.

## Test plan
- Reset, then word write 0x71FD6806 to address 0x44, then word read of 0x44 → `ready` pulses exactly LATENCY edges after each acceptance; `ReadData` = 0x71FD6806; `err` = 0; `busy` is high for LATENCY cycles each time.
- After the previous word write, byte store 0xAB to address 0x45, then word read of 0x44 → 0x71AB6806.
- Byte loads:
  - address 0x45 with `Unsigned` = 0 → 0xFFFFFFAB;
  - address 0x45 with `Unsigned` = 1 → 0x000000AB.
- Halfword loads:
  - address 0x46, signed → 0x00006806;
  - address 0x44, signed → 0x000071AB.
- Error accesses:
  - word read of 0x46 → `err` = 1, `ReadData` = 0;
  - halfword write to 0x45 → `err` = 1, and the word at 0x44 is unchanged on re-read;
  - address 4·DEPTH_WORDS → `err` = 1.
- Handshake and reset:
  - `req` held high continuously → accepted once per LATENCY+1 cycles; pulses while `busy` is high are ignored.
  - `reset` asserted mid-write (LATENCY = 3, assert at cycle 2) → no `ready` pulse; a later read of that address returns the prior contents.
